sdcard_loader: RTL and testbench
================================

SDCARD_LOADER -- requirements
Module: sdcard_loader

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 25_000_000, max cycles spent waiting on sd_busy per sector before error.
REQ-002 SHALL have parameter Simulate, default 0; when 1, effective timeout is 1000 cycles.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a transfer; sampled only in Idle.
REQ-007 start_sector  input  32  first SD sector number.
REQ-008 sector_count  input  16  number of sectors to copy.
REQ-009 dest_addr  input  32  byte address of first RAM word; bits 1:0 ignored (treated as 0).
REQ-010 busy  output  1  high from accepted start until done or error.
REQ-011 done  output  1  high from completion until next accepted start.
REQ-012 error  output  1  high from timeout until next accepted start.
REQ-013 sd_command  output  2  to sdcard: 0 idle, 1 read sector, 2 advance byte.
REQ-014 sd_sector_address  output  32  sector for sd_command 1.
REQ-015 sd_data_out  input  8  current buffer byte from sdcard.
REQ-016 sd_busy  input  1  sdcard busy (init or sector read).
REQ-017 ram_addr  output  32  word-aligned write address.
REQ-018 ram_wdata  output  32  write data, little-endian (byte n of word in bits 8n+7:8n).
REQ-019 ram_we  output  1  write request; held with stable addr/data until ram_ready.
REQ-020 ram_ready  input  1  write accepted in cycles where ram_we and ram_ready are both high.

Function
REQ-021 States SHALL be Idle, IssueRead, WaitBusyHigh, WaitBusyLow, Fetch, Write, NextSector, Done, Error.
REQ-022 Idle: start with sector_count=0 SHALL go to Done next cycle with no sd_command or RAM activity.
REQ-023 Idle: start with sector_count>0 SHALL latch inputs, set busy=1, clear done/error, go to IssueRead.
REQ-024 start outside Idle, Done or Error SHALL be ignored; Done and Error SHALL accept start exactly as Idle does.
REQ-025 IssueRead SHALL wait while sd_busy=1, then drive sd_command=1 with sd_sector_address for exactly one cycle and go to WaitBusyHigh.
REQ-026 WaitBusyHigh SHALL go to WaitBusyLow when sd_busy=1; WaitBusyLow SHALL go to Fetch, byte counter=0, when sd_busy=0.
REQ-027 Timeout counter SHALL reset on entry to WaitBusyHigh and count across both wait states; reaching the effective timeout SHALL go to Error.
REQ-028 Fetch SHALL each cycle capture sd_data_out into the word lane selected by byte counter bits 1:0, drive sd_command=2, and increment the 10-bit byte counter.
REQ-029 After capturing lane 3, Fetch SHALL go to Write; sd_command SHALL be 0 in all other states.
REQ-030 Write SHALL assert ram_we until ram_ready, then add 4 to ram_addr; go to NextSector if 512 bytes consumed, else to Fetch.
REQ-031 ram_ready asserted in the first Write cycle SHALL complete the write in that cycle (no minimum wait).
REQ-032 NextSector SHALL increment the sector and decrement the remaining count; go to Done at 0, else IssueRead.
REQ-033 Done SHALL set done=1, busy=0; Error SHALL set error=1, busy=0; ram_we SHALL be 0 in both.
REQ-034 Sector and address arithmetic SHALL wrap modulo 2^32 without flagging.

Reset
REQ-035 Asserting rst_n low SHALL immediately force Idle, busy=0, done=0, error=0, sd_command=0, ram_we=0, ram_addr=0, ram_wdata=0, sd_sector_address=0, all counters 0, including mid-transfer.

Structure
REQ-036 State enum and constant SectorBytes=512 SHALL live in package sdcard_loader_pkg.
REQ-037 No sub-module; SHALL connect directly to the sdcard block at top level.

Verification
REQ-038 start, sector=5, count=1, dest=0x100 with sdcard model -> exactly one sd_command=1 with address 5, 128 writes at 0x100..0x2FC, byte 0x11,0x22,0x33,0x44 -> word 0x44332211, done=1.
REQ-039 count=3, sector=0xFFFFFFFF -> reads at 0xFFFFFFFF, 0, 1; 384 writes; done=1.
REQ-040 count=0 -> done=1 one cycle after start, no sd_command, no ram_we.
REQ-041 Simulate=1, model holds sd_busy high -> error=1, busy=0 after 1000 wait cycles, no writes.
REQ-042 ram_ready held low 7 cycles per write -> ram_addr/ram_wdata stable while ram_we high, data intact.
REQ-043 rst_n low during word 40 of sector 1 -> all outputs reset values same cycle; new start then completes normally.

Source files
------------

// File: rtl/sdcard_loader_pkg.sv
// Shared definitions for the SD-card-to-RAM sector loader.
//   state_t        : loader FSM states
//   sd_cmd_t       : command codes presented to the sdcard block
//   SectorBytes    : bytes per SD sector
//   sector_consumed: true once a whole sector has been pulled from the card
package sdcard_loader_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StIssueRead,
    StWaitBusyHigh,
    StWaitBusyLow,
    StFetch,
    StWrite,
    StNextSector,
    StDone,
    StError
  } state_t;

  typedef enum logic [1:0] {
    SdIdle    = 2'd0,
    SdRead    = 2'd1,
    SdAdvance = 2'd2
  } sd_cmd_t;

  localparam int SectorBytes = 512;

  // The byte counter is 10 bits so that 512 itself is representable.
  function automatic logic sector_consumed(input logic [9:0] cnt);
    return cnt == 10'(SectorBytes);
  endfunction

endpackage

// File: rtl/sdcard_loader.sv
// Copies a run of SD sectors into RAM as little-endian 32-bit words.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start               : one-cycle request, honoured in Idle/Done/Error
//   start_sector        : first SD sector number
//   sector_count        : number of sectors to copy (0 completes immediately)
//   dest_addr           : byte address of first RAM word (bits 1:0 dropped)
//   busy, done, error   : transfer status
//   sd_command          : 0 idle, 1 read sector, 2 advance byte
//   sd_sector_address   : sector for a read command
//   sd_data_out         : current byte from the card buffer
//   sd_busy             : card busy (init or sector read)
//   ram_addr, ram_wdata : word-aligned write address and data
//   ram_we, ram_ready   : write request, accepted when both high
module sdcard_loader
  import sdcard_loader_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 25_000_000,
  parameter bit          Simulate      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] start_sector,
  input  logic [15:0] sector_count,
  input  logic [31:0] dest_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  sd_command,
  output logic [31:0] sd_sector_address,
  input  logic [7:0]  sd_data_out,
  input  logic        sd_busy,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic        ram_ready
);

  localparam int unsigned EffTimeout  = Simulate ? 32'd1000 : TimeoutCycles;
  // Last permissible wait-cycle index; reaching it ends the wait in Error.
  localparam logic [31:0] TimeoutLast = 32'(EffTimeout - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_sector;
  logic [15:0] r_remaining;
  logic [31:0] r_ram_addr;
  logic [31:0] r_wdata;
  logic [9:0]  r_byte_cnt;
  logic [31:0] r_timer;
  logic        w_timeout;
  logic        w_accept;

  assign w_timeout = (r_timer >= TimeoutLast);
  assign w_accept  = start && ((r_state == StIdle) || (r_state == StDone) ||
                               (r_state == StError));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_sector    <= '0;
      r_remaining <= '0;
      r_ram_addr  <= '0;
      r_wdata     <= '0;
      r_byte_cnt  <= '0;
      r_timer     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        StIdle, StDone, StError: begin
          if (w_accept && (sector_count != 16'd0)) begin
            r_sector    <= start_sector;
            r_remaining <= sector_count;
            r_ram_addr  <= {dest_addr[31:2], 2'b00};
            r_byte_cnt  <= '0;
            r_timer     <= '0;
          end
        end
        StIssueRead: begin
          if (!sd_busy) r_timer <= '0;
        end
        StWaitBusyHigh: begin
          r_timer <= r_timer + 32'd1;
        end
        StWaitBusyLow: begin
          r_timer <= r_timer + 32'd1;
          if (!sd_busy) r_byte_cnt <= '0;
        end
        StFetch: begin
          r_wdata[{r_byte_cnt[1:0], 3'b000} +: 8] <= sd_data_out;
          r_byte_cnt <= r_byte_cnt + 10'd1;
        end
        StWrite: begin
          if (ram_ready) r_ram_addr <= r_ram_addr + 32'd4;
        end
        StNextSector: begin
          r_sector    <= r_sector + 32'd1;
          r_remaining <= r_remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      StIdle, StDone, StError: begin
        if (w_accept) w_next = (sector_count == 16'd0) ? StDone : StIssueRead;
      end
      StIssueRead: begin
        if (!sd_busy) w_next = StWaitBusyHigh;
      end
      StWaitBusyHigh: begin
        if (w_timeout)    w_next = StError;
        else if (sd_busy) w_next = StWaitBusyLow;
      end
      StWaitBusyLow: begin
        // A card that finishes on the last allowed cycle still wins.
        if (!sd_busy)       w_next = StFetch;
        else if (w_timeout) w_next = StError;
      end
      StFetch: begin
        if (r_byte_cnt[1:0] == 2'd3) w_next = StWrite;
      end
      StWrite: begin
        if (ram_ready) w_next = sector_consumed(r_byte_cnt) ? StNextSector : StFetch;
      end
      StNextSector: begin
        w_next = (r_remaining == 16'd1) ? StDone : StIssueRead;
      end
      default: w_next = StIdle;
    endcase
  end

  // Outputs decoded from state so reset clears them immediately
  always_comb begin
    sd_command = SdIdle;
    ram_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (r_state)
      StIdle:      busy = 1'b0;
      StIssueRead: if (!sd_busy) sd_command = SdRead;
      StFetch:     sd_command = SdAdvance;
      StWrite:     ram_we = 1'b1;
      StDone: begin
        busy = 1'b0;
        done = 1'b1;
      end
      StError: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: ;
    endcase
  end

  assign sd_sector_address = r_sector;
  assign ram_addr          = r_ram_addr;
  assign ram_wdata         = r_wdata;

endmodule

// File: tb/tb_sdcard_loader.sv
// Randomised scoreboard bench for sdcard_loader with a behavioural SD card
// and a RAM port whose acceptance latency is either fixed or random.
module tb_sdcard_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_sector = '0;
  logic [15:0] sector_count = '0;
  logic [31:0] dest_addr = '0;
  logic        busy, done, error;
  logic [1:0]  sd_command;
  logic [31:0] sd_sector_address;
  logic [7:0]  sd_data_out;
  logic        sd_busy = 1'b1;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_we;
  logic        ram_ready;

  always #5 clk = ~clk;

  sdcard_loader #(.TimeoutCycles(25_000_000), .Simulate(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_sector(start_sector),
    .sector_count(sector_count), .dest_addr(dest_addr), .busy(busy),
    .done(done), .error(error), .sd_command(sd_command),
    .sd_sector_address(sd_sector_address), .sd_data_out(sd_data_out),
    .sd_busy(sd_busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_ready(ram_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h expected=none", nm, act);
  endtask

  // ---------------- card content model ----------------
  bit          pat_fixed = 1'b1;
  logic [31:0] pat_seed = 32'h0;
  bit          hang = 1'b0;

  function automatic logic [7:0] dbyte(input logic [31:0] sec, input int idx,
                                       input bit fixed, input logic [31:0] seed);
    logic [31:0] h;
    if (fixed) return 8'(((idx % 4) + 1) * 17);
    h = (sec ^ seed) + 32'(idx) * 32'h9E37;
    h = h ^ (h >> 7);
    return h[7:0] ^ h[15:8];
  endfunction

  logic [31:0] m_sector = '0;
  int          m_ptr = 0;
  int          m_busy_cnt = 40;

  assign sd_data_out = dbyte(m_sector, m_ptr, pat_fixed, pat_seed);

  always @(posedge clk) begin
    if (sd_command == 2'd1) begin
      m_sector   <= sd_sector_address;
      m_ptr      <= 0;
      sd_busy    <= 1'b1;
      m_busy_cnt <= int'($urandom_range(1, 6));
    end else begin
      if (sd_busy && !hang) begin
        if (m_busy_cnt <= 1) sd_busy <= 1'b0;
        m_busy_cnt <= m_busy_cnt - 1;
      end
      if (sd_command == 2'd2) m_ptr <= m_ptr + 1;
    end
  end

  // ---------------- RAM acceptance model ----------------
  int hold_fixed = 0;   // negative selects a random wait per write
  int hold_rand = 0;
  int w_cnt = 0;

  assign ram_ready = ram_we && (w_cnt >= ((hold_fixed >= 0) ? hold_fixed : hold_rand));

  always @(posedge clk) begin
    if (ram_we && ram_ready) begin
      w_cnt     <= 0;
      hold_rand <= int'($urandom_range(0, 3));
    end else if (ram_we) begin
      w_cnt <= w_cnt + 1;
    end else begin
      w_cnt <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] rq[$];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  int          hs = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] pend_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sd_command == 2'd1) begin
        if (rq.size() == 0) unexpected("rd_cmd", sd_sector_address);
        else check("rd_sector", sd_sector_address, rq.pop_front());
      end
      if (ram_we && pend) begin
        check("we_addr_stable", ram_addr, pend_addr);
        check("we_data_stable", ram_wdata, pend_data);
      end
      if (ram_we && ram_ready) begin
        hs <= hs + 1;
        wlog_addr.push_back(ram_addr);
        wlog_data.push_back(ram_wdata);
        if (wq_addr.size() == 0) unexpected("ram_write", ram_addr);
        else begin
          check("wr_addr", ram_addr, wq_addr.pop_front());
          check("wr_data", ram_wdata, wq_data.pop_front());
        end
      end
      pend      <= ram_we && !ram_ready;
      pend_addr <= ram_addr;
      pend_data <= ram_wdata;
    end else begin
      pend <= 1'b0;
    end
  end

  // Expected traffic for a transfer, from the loader's contract.
  task automatic push_expect(input logic [31:0] sec0, input int cnt,
                             input logic [31:0] dest, input bit writes);
    logic [31:0] a;
    logic [31:0] sec;
    a = {dest[31:2], 2'b00};
    for (int s = 0; s < cnt; s++) begin
      sec = sec0 + 32'(s);
      rq.push_back(sec);
      if (writes) begin
        for (int w = 0; w < 128; w++) begin
          wq_addr.push_back(a);
          wq_data.push_back({dbyte(sec, 4*w+3, pat_fixed, pat_seed),
                             dbyte(sec, 4*w+2, pat_fixed, pat_seed),
                             dbyte(sec, 4*w+1, pat_fixed, pat_seed),
                             dbyte(sec, 4*w,   pat_fixed, pat_seed)});
          a = a + 32'd4;
        end
      end
    end
  endtask

  task automatic do_start(input logic [31:0] sec, input int cnt, input logic [31:0] dest);
    @(negedge clk);
    start        = 1'b1;
    start_sector = sec;
    sector_count = 16'(cnt);
    dest_addr    = dest;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done || error) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_transfer(input logic [31:0] sec, input int cnt, input logic [31:0] dest);
    bit ok;
    int base;
    base = hs;
    push_expect(sec, cnt, dest, 1'b1);
    do_start(sec, cnt, dest);
    check("busy_after_start", busy, 1'b1);
    check("done_cleared", done, 1'b0);
    wait_end(6000 * cnt + 200, ok);
    check("end_reached", ok, 1'b1);
    @(negedge clk);
    check("done", done, 1'b1);
    check("error", error, 1'b0);
    check("busy_end", busy, 1'b0);
    check("writes", hs - base, cnt * 128);
    check("rq_left", rq.size(), 0);
    check("wq_left", wq_addr.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_sd_command", sd_command, 2'd0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_sd_addr", sd_sector_address, 32'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    int t_cmd;
    int t_err;
    bit ok;
    logic [31:0] sec;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Zero-length request from Idle completes on the next cycle.
    do_start(32'h1234, 0, 32'h40);
    check("cnt0_done", done, 1'b1);
    check("cnt0_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    check("cnt0_done_hold", done, 1'b1);

    // Single sector with the fixed byte pattern.
    pat_fixed  = 1'b1;
    hold_fixed = 0;
    base = hs;
    run_transfer(32'd5, 1, 32'h100);
    check("first_addr", wlog_addr[base], 32'h100);
    check("last_addr", wlog_addr[base + 127], 32'h2FC);
    check("first_word", wlog_data[base], 32'h44332211);

    // Sector numbers wrap past 2^32-1.
    pat_fixed  = 1'b0;
    pat_seed   = $urandom;
    hold_fixed = -1;
    run_transfer(32'hFFFF_FFFF, 3, $urandom);

    // Slow RAM: each write waits seven cycles.
    hold_fixed = 7;
    pat_seed   = $urandom;
    run_transfer($urandom, 1, $urandom);

    // Random transfers, including unaligned and wrapping destinations.
    hold_fixed = -1;
    for (int k = 0; k < 3; k++) begin
      pat_seed = $urandom;
      run_transfer($urandom, int'($urandom_range(1, 2)),
                   (k == 0) ? 32'hFFFF_FF03 : $urandom);
    end

    // Reset in the middle of word 40 of the second sector.
    pat_seed = $urandom;
    sec = $urandom;
    base = hs;
    push_expect(sec, 3, 32'h2000, 1'b1);
    do_start(sec, 3, 32'h2000);
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if (hs >= base + 168) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_word40", ok, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    rq.delete();
    wq_addr.delete();
    wq_data.delete();
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    run_transfer($urandom, 1, $urandom);

    // Card never finishes its read: timeout after 1000 wait cycles.
    hang = 1'b1;
    base = hs;
    sec = $urandom;
    push_expect(sec, 1, 32'h0, 1'b0);
    do_start(sec, 1, 32'h0);
    t_cmd = -1;
    t_err = -1;
    for (t = 0; t < 3000; t++) begin
      if (sd_command == 2'd1 && t_cmd < 0) t_cmd = t;
      if (error) begin
        t_err = t;
        break;
      end
      @(negedge clk);
    end
    check("timeout_seen", (t_err >= 0 && t_cmd >= 0), 1'b1);
    check("timeout_cycles", t_err - t_cmd, 1001);
    check("to_error", error, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_done", done, 1'b0);
    check("to_writes", hs - base, 0);
    check("to_rq_left", rq.size(), 0);

    // Error state accepts a fresh start once the card recovers.
    hang = 1'b0;
    pat_seed = $urandom;
    run_transfer($urandom, 1, $urandom);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
